// File: rtl/sf_snp_ctrl_if.sv
// Bundles the SLC request, snoop-filter array and snoop channels of the HN-F snoop sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding fabric.
interface sf_snp_ctrl_if #(
    parameter int NUM_RN   = 4,
    parameter int ADDR_W   = 48,
    parameter int RN_IDX_W = (NUM_RN > 1) ? $clog2(NUM_RN) : 1
);
    logic                req_v;
    logic                req_rdy;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_unique;
    logic [RN_IDX_W-1:0] req_src;

    logic                sf_lkp_v;
    logic [ADDR_W-1:0]   sf_lkp_addr;
    logic                sf_hit;
    logic                sf_hit_uniq;
    logic [NUM_RN-1:0]   sf_hit_vec;

    logic                sf_upd_v;
    logic [ADDR_W-1:0]   sf_upd_addr;
    logic [NUM_RN-1:0]   sf_upd_vec;
    logic                sf_upd_uniq;

    logic                snp_v;
    logic                snp_rdy;
    logic [RN_IDX_W-1:0] snp_tgt;
    logic [ADDR_W-1:0]   snp_addr;
    logic                snp_inv;
    logic                snp_rsp_v;
    logic [RN_IDX_W-1:0] snp_rsp_src;

    logic                done_v;

    modport slave (
        input  req_v, req_addr, req_unique, req_src,
        input  sf_hit, sf_hit_uniq, sf_hit_vec,
        input  snp_rdy, snp_rsp_v, snp_rsp_src,
        output req_rdy, sf_lkp_v, sf_lkp_addr,
        output sf_upd_v, sf_upd_addr, sf_upd_vec, sf_upd_uniq,
        output snp_v, snp_tgt, snp_addr, snp_inv, done_v
    );

    modport master (
        output req_v, req_addr, req_unique, req_src,
        output sf_hit, sf_hit_uniq, sf_hit_vec,
        output snp_rdy, snp_rsp_v, snp_rsp_src,
        input  req_rdy, sf_lkp_v, sf_lkp_addr,
        input  sf_upd_v, sf_upd_addr, sf_upd_vec, sf_upd_uniq,
        input  snp_v, snp_tgt, snp_addr, snp_inv, done_v
    );
endinterface

// File: rtl/sf_snp_ctrl.sv
// HN-F snoop-filter sequencer: one coherent read at a time, serial snoops in ascending RN order,
// then a single sharer-vector write-back and a done pulse. All outputs are registered.
module sf_snp_ctrl #(
    parameter int NUM_RN   = 4,
    parameter int ADDR_W   = 48,
    parameter int RN_IDX_W = (NUM_RN > 1) ? $clog2(NUM_RN) : 1
) (
    input  logic          clock,
    input  logic          reset,
    sf_snp_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, LOOKUP, SNOOP, WAIT_RSP, UPDATE, DONE
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                unique_reg;
    logic [RN_IDX_W-1:0] src_reg;
    logic [NUM_RN-1:0]   pend_reg;
    logic [NUM_RN-1:0]   new_vec_reg;
    logic                new_uniq_reg;

    logic                req_rdy_reg;
    logic                sf_lkp_v_reg;
    logic [ADDR_W-1:0]   sf_lkp_addr_reg;
    logic                sf_upd_v_reg;
    logic [ADDR_W-1:0]   sf_upd_addr_reg;
    logic [NUM_RN-1:0]   sf_upd_vec_reg;
    logic                sf_upd_uniq_reg;
    logic                snp_v_reg;
    logic [RN_IDX_W-1:0] snp_tgt_reg;
    logic [ADDR_W-1:0]   snp_addr_reg;
    logic                snp_inv_reg;
    logic                done_v_reg;

    logic [NUM_RN-1:0]   src_onehot;
    logic [NUM_RN-1:0]   tgt_onehot;
    logic [NUM_RN-1:0]   lkp_pend;
    logic [NUM_RN-1:0]   lkp_vec;
    logic                lkp_uniq;
    logic [NUM_RN-1:0]   pend_clr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RN; gi++) begin : g_onehot
            assign src_onehot[gi] = (src_reg == RN_IDX_W'(gi));
            assign tgt_onehot[gi] = (snp_tgt_reg == RN_IDX_W'(gi));
        end
    endgenerate

    function automatic logic [RN_IDX_W-1:0] lowest_idx(input logic [NUM_RN-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_RN - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = RN_IDX_W'(i);
        end
    endfunction

    // Snoop decision from the combinational lookup result; only meaningful while in LOOKUP.
    always_comb begin
        lkp_pend = '0;
        lkp_vec  = src_onehot;
        lkp_uniq = unique_reg;
        if (bus.sf_hit) begin
            if (unique_reg) begin
                lkp_pend = bus.sf_hit_vec & ~src_onehot;
                lkp_uniq = 1'b1;
            end else begin
                lkp_vec  = bus.sf_hit_vec | src_onehot;
                lkp_uniq = 1'b0;
                if (bus.sf_hit_uniq && ((bus.sf_hit_vec & ~src_onehot) != '0))
                    lkp_pend = bus.sf_hit_vec;
            end
        end
        pend_clr = pend_reg & ~tgt_onehot;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            unique_reg      <= 1'b0;
            src_reg         <= '0;
            pend_reg        <= '0;
            new_vec_reg     <= '0;
            new_uniq_reg    <= 1'b0;
            req_rdy_reg     <= 1'b1;
            sf_lkp_v_reg    <= 1'b0;
            sf_lkp_addr_reg <= '0;
            sf_upd_v_reg    <= 1'b0;
            sf_upd_addr_reg <= '0;
            sf_upd_vec_reg  <= '0;
            sf_upd_uniq_reg <= 1'b0;
            snp_v_reg       <= 1'b0;
            snp_tgt_reg     <= '0;
            snp_addr_reg    <= '0;
            snp_inv_reg     <= 1'b0;
            done_v_reg      <= 1'b0;
        end else begin
            sf_lkp_v_reg <= 1'b0;
            sf_upd_v_reg <= 1'b0;
            done_v_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.req_v && req_rdy_reg) begin
                        addr_reg        <= bus.req_addr;
                        unique_reg      <= bus.req_unique;
                        src_reg         <= bus.req_src;
                        req_rdy_reg     <= 1'b0;
                        sf_lkp_v_reg    <= 1'b1;
                        sf_lkp_addr_reg <= bus.req_addr;
                        state_reg       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    pend_reg     <= lkp_pend;
                    new_vec_reg  <= lkp_vec;
                    new_uniq_reg <= lkp_uniq;
                    if (lkp_pend != '0) begin
                        snp_v_reg    <= 1'b1;
                        snp_tgt_reg  <= lowest_idx(lkp_pend);
                        snp_addr_reg <= addr_reg;
                        snp_inv_reg  <= unique_reg;
                        state_reg    <= SNOOP;
                    end else begin
                        sf_upd_v_reg    <= 1'b1;
                        sf_upd_addr_reg <= addr_reg;
                        sf_upd_vec_reg  <= lkp_vec;
                        sf_upd_uniq_reg <= lkp_uniq;
                        state_reg       <= UPDATE;
                    end
                end
                SNOOP: begin
                    if (bus.snp_rdy) begin
                        snp_v_reg <= 1'b0;
                        state_reg <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (bus.snp_rsp_v && (bus.snp_rsp_src == snp_tgt_reg)) begin
                        pend_reg <= pend_clr;
                        if (pend_clr != '0) begin
                            snp_v_reg   <= 1'b1;
                            snp_tgt_reg <= lowest_idx(pend_clr);
                            state_reg   <= SNOOP;
                        end else begin
                            sf_upd_v_reg    <= 1'b1;
                            sf_upd_addr_reg <= addr_reg;
                            sf_upd_vec_reg  <= new_vec_reg;
                            sf_upd_uniq_reg <= new_uniq_reg;
                            state_reg       <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    done_v_reg <= 1'b1;
                    state_reg  <= DONE;
                end
                default: begin
                    req_rdy_reg <= 1'b1;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_rdy     = req_rdy_reg;
    assign bus.sf_lkp_v    = sf_lkp_v_reg;
    assign bus.sf_lkp_addr = sf_lkp_addr_reg;
    assign bus.sf_upd_v    = sf_upd_v_reg;
    assign bus.sf_upd_addr = sf_upd_addr_reg;
    assign bus.sf_upd_vec  = sf_upd_vec_reg;
    assign bus.sf_upd_uniq = sf_upd_uniq_reg;
    assign bus.snp_v       = snp_v_reg;
    assign bus.snp_tgt     = snp_tgt_reg;
    assign bus.snp_addr    = snp_addr_reg;
    assign bus.snp_inv     = snp_inv_reg;
    assign bus.done_v      = done_v_reg;
endmodule

// File: tb/tb_sf_snp_ctrl.sv
// Directed bench for sf_snp_ctrl: stimulus pushes expected lookups, snoops, updates and done
// latencies into queues; a monitor pops and compares whenever the sequencer presents one.
module tb_sf_snp_ctrl;
    localparam int NUM_RN   = 4;
    localparam int ADDR_W   = 48;
    localparam int RN_IDX_W = 2;

    typedef struct {
        logic [RN_IDX_W-1:0] tgt;
        logic [ADDR_W-1:0]   addr;
        logic                inv;
    } snp_exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [NUM_RN-1:0] vec;
        logic              uniq;
    } upd_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sf_snp_ctrl_if #(.NUM_RN(NUM_RN), .ADDR_W(ADDR_W), .RN_IDX_W(RN_IDX_W)) bus ();

    sf_snp_ctrl #(.NUM_RN(NUM_RN), .ADDR_W(ADDR_W), .RN_IDX_W(RN_IDX_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [ADDR_W-1:0] lkp_q[$];
    snp_exp_t          snp_q[$];
    upd_exp_t          upd_q[$];
    int                done_q[$];   // >0: exact latency, <0: minimum latency of -value

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: output seen with no expectation queued", name);
    endtask

    // Monitor: samples after the drivers settle, so req/snp handshakes match the next posedge.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            cyc++;
            if (!reset) begin
                if (bus.req_v && bus.req_rdy) acc_cyc = cyc;
                if (bus.sf_lkp_v) begin
                    if (lkp_q.size() == 0) unexpected("lkp");
                    else chk("lkp_addr", 64'(bus.sf_lkp_addr), 64'(lkp_q.pop_front()));
                end
                if (bus.snp_v && bus.snp_rdy) begin
                    if (snp_q.size() == 0) unexpected("snp");
                    else begin
                        snp_exp_t e;
                        e = snp_q.pop_front();
                        chk("snp_tgt",  64'(bus.snp_tgt),  64'(e.tgt));
                        chk("snp_addr", 64'(bus.snp_addr), 64'(e.addr));
                        chk("snp_inv",  64'(bus.snp_inv),  64'(e.inv));
                        $display("snoop tgt=%0d addr=0x%0h inv=%0d", bus.snp_tgt, bus.snp_addr, bus.snp_inv);
                    end
                end
                if (bus.sf_upd_v) begin
                    if (upd_q.size() == 0) unexpected("upd");
                    else begin
                        upd_exp_t u;
                        u = upd_q.pop_front();
                        chk("upd_addr", 64'(bus.sf_upd_addr), 64'(u.addr));
                        chk("upd_vec",  64'(bus.sf_upd_vec),  64'(u.vec));
                        chk("upd_uniq", 64'(bus.sf_upd_uniq), 64'(u.uniq));
                        $display("update addr=0x%0h vec=%b uniq=%0d", bus.sf_upd_addr, bus.sf_upd_vec, bus.sf_upd_uniq);
                    end
                end
                if (bus.done_v) begin
                    if (done_q.size() == 0) unexpected("done");
                    else begin
                        int e;
                        int lat;
                        e = done_q.pop_front();
                        lat = cyc - acc_cyc;
                        if (e > 0) chk("done_lat", 64'(lat), 64'(e));
                        else       chk("done_lat_min", 64'(lat >= -e), 64'd1);
                        $display("done latency=%0d", lat);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [ADDR_W-1:0] a, input logic u, input logic [RN_IDX_W-1:0] s,
                         input logic h, input logic hu, input logic [NUM_RN-1:0] hv);
        int t = 0;
        @(negedge clock); #1;
        while (!bus.req_rdy && t < 50) begin
            @(negedge clock); #1;
            t++;
        end
        if (!bus.req_rdy) unexpected("req_rdy_timeout");
        lkp_q.push_back(a);
        bus.req_v       = 1'b1;
        bus.req_addr    = a;
        bus.req_unique  = u;
        bus.req_src     = s;
        bus.sf_hit      = h;
        bus.sf_hit_uniq = hu;
        bus.sf_hit_vec  = hv;
        @(negedge clock); #1;
        bus.req_v    = 1'b0;
        bus.req_addr = '0;
    endtask

    task automatic serve_snoop(input logic [RN_IDX_W-1:0] tgt, input logic [ADDR_W-1:0] a,
                               input int delay, input bit stray, input logic [RN_IDX_W-1:0] stray_src,
                               input bit respond);
        int t = 0;
        while (!bus.snp_v && t < 50) begin
            @(negedge clock); #1;
            t++;
        end
        if (!bus.snp_v) begin
            unexpected("snp_v_timeout");
            return;
        end
        for (int i = 0; i < delay; i++) begin
            chk("snp_v_hold",    64'(bus.snp_v),    64'd1);
            chk("snp_tgt_hold",  64'(bus.snp_tgt),  64'(tgt));
            chk("snp_addr_hold", 64'(bus.snp_addr), 64'(a));
            @(negedge clock); #1;
        end
        bus.snp_rdy = 1'b1;
        @(negedge clock); #1;
        bus.snp_rdy = 1'b0;
        if (stray) begin
            bus.snp_rsp_v   = 1'b1;
            bus.snp_rsp_src = stray_src;
            @(negedge clock); #1;
            bus.snp_rsp_v = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk("stray_no_snp", 64'(bus.snp_v),    64'd0);
                chk("stray_no_upd", 64'(bus.sf_upd_v), 64'd0);
                @(negedge clock); #1;
            end
        end
        if (respond) begin
            bus.snp_rsp_v   = 1'b1;
            bus.snp_rsp_src = tgt;
            @(negedge clock); #1;
            bus.snp_rsp_v = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!bus.req_rdy && t < 60) begin
            @(negedge clock); #1;
            t++;
        end
        if (!bus.req_rdy) unexpected("idle_timeout");
    endtask

    initial begin
        bus.req_v = 0; bus.req_addr = '0; bus.req_unique = 0; bus.req_src = '0;
        bus.sf_hit = 0; bus.sf_hit_uniq = 0; bus.sf_hit_vec = '0;
        bus.snp_rdy = 0; bus.snp_rsp_v = 0; bus.snp_rsp_src = '0;
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        chk("rst_req_rdy",  64'(bus.req_rdy),    64'd1);
        chk("rst_lkp_v",    64'(bus.sf_lkp_v),   64'd0);
        chk("rst_upd_v",    64'(bus.sf_upd_v),   64'd0);
        chk("rst_snp_v",    64'(bus.snp_v),      64'd0);
        chk("rst_done_v",   64'(bus.done_v),     64'd0);
        chk("rst_upd_vec",  64'(bus.sf_upd_vec), 64'd0);
        chk("rst_snp_tgt",  64'(bus.snp_tgt),    64'd0);
        chk("rst_snp_addr", 64'(bus.snp_addr),   64'd0);

        // Miss, ReadShared from RN2
        upd_q.push_back('{48'h1000, 4'b0100, 1'b0});
        done_q.push_back(3);
        issue(48'h1000, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000);
        wait_idle();

        // ReadUnique hit from RN0: invalidate RN1 then RN3
        snp_q.push_back('{2'd1, 48'h2040, 1'b1});
        snp_q.push_back('{2'd3, 48'h2040, 1'b1});
        upd_q.push_back('{48'h2040, 4'b0001, 1'b1});
        done_q.push_back(-7);
        issue(48'h2040, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1011);
        serve_snoop(2'd1, 48'h2040, 0, 1'b0, 2'd0, 1'b1);
        serve_snoop(2'd3, 48'h2040, 2, 1'b0, 2'd0, 1'b1);
        wait_idle();

        // ReadShared on unique owner RN2, with backpressure and a stray response from RN0
        snp_q.push_back('{2'd2, 48'h3080, 1'b0});
        upd_q.push_back('{48'h3080, 4'b0110, 1'b0});
        done_q.push_back(-5);
        issue(48'h3080, 1'b0, 2'd1, 1'b1, 1'b1, 4'b0100);
        serve_snoop(2'd2, 48'h3080, 5, 1'b1, 2'd0, 1'b1);
        wait_idle();

        // Shared hit, no snoop needed
        upd_q.push_back('{48'h40c0, 4'b1001, 1'b0});
        done_q.push_back(3);
        issue(48'h40c0, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0001);
        wait_idle();

        // Reset while waiting for a snoop response: no update or done may follow
        snp_q.push_back('{2'd0, 48'h5100, 1'b1});
        issue(48'h5100, 1'b1, 2'd3, 1'b1, 1'b0, 4'b0111);
        serve_snoop(2'd0, 48'h5100, 1, 1'b0, 2'd0, 1'b0);
        reset = 1'b1;
        @(negedge clock); #1;
        chk("mid_rst_req_rdy", 64'(bus.req_rdy),  64'd1);
        chk("mid_rst_snp_v",   64'(bus.snp_v),    64'd0);
        chk("mid_rst_upd_v",   64'(bus.sf_upd_v), 64'd0);
        chk("mid_rst_done_v",  64'(bus.done_v),   64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Miss ReadUnique after reset completes normally
        upd_q.push_back('{48'h6140, 4'b0010, 1'b1});
        done_q.push_back(3);
        issue(48'h6140, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000);
        wait_idle();

        repeat (5) @(negedge clock);
        chk("lkp_q_empty",  64'(lkp_q.size()),  64'd0);
        chk("snp_q_empty",  64'(snp_q.size()),  64'd0);
        chk("upd_q_empty",  64'(upd_q.size()),  64'd0);
        chk("done_q_empty", 64'(done_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/sf_snp_ctrl.md
Name: sf_snp_ctrl

Overview:
- Home-node (HN-F) snoop-filter sequencer between the SLC request path and the snoop-filter array.
- Takes one coherent read at a time from the SLC, looks it up in the snoop filter and issues any required snoops serially to RN-Fs.
- Collects snoop responses, writes the updated sharer vector back to the snoop filter, then signals completion.
- Single outstanding transaction; no internal storage beyond one transaction context.

Parameters:
- NUM_RN, 4, number of RN-Fs tracked (sharer-vector width).
- ADDR_W, 48, request address width.
- RN_IDX_W, $clog2(NUM_RN), RN index width (minimum 1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_v  in  1  SLC request valid
- req_rdy  out  1  controller can accept a request
- req_addr  in  ADDR_W  line address
- req_unique  in  1  1 = ReadUnique, 0 = ReadShared
- req_src  in  RN_IDX_W  requesting RN-F index
- sf_lkp_v  out  1  snoop-filter lookup strobe
- sf_lkp_addr  out  ADDR_W  lookup address
- sf_hit  in  1  lookup hit (combinational, valid in the cycle sf_lkp_v=1)
- sf_hit_uniq  in  1  hit line held Unique by a single RN-F
- sf_hit_vec  in  NUM_RN  sharer vector of the hit line
- sf_upd_v  out  1  write-back strobe, one cycle
- sf_upd_addr  out  ADDR_W  update address
- sf_upd_vec  out  NUM_RN  new sharer vector
- sf_upd_uniq  out  1  new unique flag
- snp_v  out  1  snoop request valid
- snp_rdy  in  1  snoop channel ready
- snp_tgt  out  RN_IDX_W  snoop target RN-F
- snp_addr  out  ADDR_W  snoop address
- snp_inv  out  1  1 = SnpUnique (invalidate), 0 = SnpShared
- snp_rsp_v  in  1  snoop response valid (single beat)
- snp_rsp_src  in  RN_IDX_W  responding RN-F
- done_v  out  1  transaction complete pulse

Behaviour:
- States: IDLE, LOOKUP, SNOOP, WAIT_RSP, UPDATE, DONE.
- Reset: state=IDLE, pending vector=0. req_rdy=1; sf_lkp_v, sf_upd_v, snp_v and done_v are 0; the address, vector and target outputs are 0.
- IDLE: req_rdy=1. On req_v & req_rdy, latch addr/unique/src and go to LOOKUP. req_rdy=0 in every other state.
- LOOKUP (1 cycle): sf_lkp_v=1, sf_lkp_addr=latched addr. Sample sf_hit, sf_hit_uniq and sf_hit_vec, then compute pending snoop targets (pend):
  - miss: pend=0; new_vec=onehot(src); new_uniq=req_unique.
  - hit, unique request: pend=hit_vec & ~onehot(src); new_vec=onehot(src); new_uniq=1; snp_inv=1.
  - hit, shared request, hit_uniq=1 and owner != src: pend=hit_vec; new_vec=hit_vec | onehot(src); new_uniq=0; snp_inv=0.
  - hit, shared request, otherwise: pend=0; new_vec=hit_vec | onehot(src); new_uniq=0.
  - Next state: SNOOP if pend!=0, else UPDATE.
- SNOOP: snp_v=1, snp_tgt=lowest set bit of pend. snp_addr and snp_inv hold stable until snp_rdy. On snp_v & snp_rdy go to WAIT_RSP. snp_v never drops before the handshake.
- WAIT_RSP: on snp_rsp_v with snp_rsp_src == the current target, clear that bit of pend. Then go to SNOOP if pend!=0, else UPDATE.
  - Responses from any other source are ignored.
  - A response arriving in any state other than WAIT_RSP is ignored.
- UPDATE (1 cycle): sf_upd_v=1 with sf_upd_addr, sf_upd_vec and sf_upd_uniq, then go to DONE.
- DONE (1 cycle): done_v=1, then go to IDLE. req_rdy rises the following cycle, so back-to-back throughput is at least 4 cycles per request.
- Minimum latency from accept to done_v:
  - no snoops: 3 cycles (LOOKUP, UPDATE, DONE);
  - each snoop adds at least 2 cycles.
- Snoops are issued strictly one at a time, in ascending RN index order. The requester is never snooped.
- reset asserted mid-transaction: return to IDLE next edge, all outputs return to reset values, no sf_upd_v issued, and the context is discarded.
- req_v while busy: held off by req_rdy=0. The controller has no requirement on the SLC to keep req_v asserted.

Test Plan:
- Miss: reset, ReadShared addr=0x1000, src=2, sf_hit=0 -> no snp_v; sf_upd_vec=4'b0100, uniq=0; done_v 3 cycles after accept.
- ReadUnique hit: src=0, hit_vec=4'b1011 -> SnpUnique to RN1 then RN3 in that order, each held until snp_rdy; after both responses sf_upd_vec=4'b0001, uniq=1, one done_v.
- ReadShared on unique owner: src=1, hit_uniq=1, hit_vec=4'b0100 -> one SnpShared to RN2, snp_inv=0; sf_upd_vec=4'b0110, uniq=0.
- Backpressure and stray response: snp_rdy low for 5 cycles -> snp_v, tgt and addr stable. A response from the wrong src while in WAIT_RSP -> ignored, state stays WAIT_RSP until the correct src responds.
- Reset mid-snoop: assert reset during WAIT_RSP -> next cycle IDLE, req_rdy=1, no sf_upd_v or done_v. A following miss request completes normally.
- Shared hit, no snoop: ReadShared src=3, hit_vec=4'b0001, hit_uniq=0 -> no snoop; sf_upd_vec=4'b1001.
